control_sequencer: RTL

Microcoded control unit that sequences fetch/execute T-states and drives every control line of the 8-bit datapath, including the `countEnable` and `jump` strobes consumed by the program counter. It decodes the opcode nibble of the instruction register and the registered carry/zero flags into one-hot-ish control words. It is a 3-bit step counter plus a halt latch. All outputs are decoded from registered state and stable inputs, so every control line is valid for the whole clock period before the edge that acts on it.

---
 rtl/control_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Five-step fetch/execute sequencer with a halt latch. Every control line is
// decoded combinationally from the registered step, the halt latch, the opcode, the flags and reset.
module control_sequencer #(
   parameter bit HALT_ON_UNDEFINED = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       carryFlag,
   input  logic       zeroFlag,
   output logic       hlt,
   output logic       marIn,
   output logic       ramIn,
   output logic       ramOut,
   output logic       irIn,
   output logic       irOut,
   output logic       aIn,
   output logic       aOut,
   output logic       bIn,
   output logic       sumOut,
   output logic       subtract,
   output logic       outIn,
   output logic       flagsIn,
   output logic       pcOut,
   output logic       countEnable,
   output logic       jump,
   output logic [2:0] step
);

   // state | meaning
   // T0    | fetch: PC onto bus, MAR load
   // T1    | fetch: RAM onto bus, IR load, PC increment
   // T2    | execute 1 (HLT sets the halt latch on the closing edge)
   // T3    | execute 2; also the frozen step while halted
   // T4    | execute 3
   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} t_state_e;

   t_state_e   r_step;
   logic       r_halt;
   logic [3:0] w_op;
   logic       w_is_hlt;
   logic       w_unused;

   assign w_op     = instr[7:4];
   assign w_unused = ^instr[3:0];
   assign w_is_hlt = (w_op == 4'hF) ||
                     (HALT_ON_UNDEFINED && (w_op >= 4'h9) && (w_op <= 4'hD));
   assign step     = r_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_step <= T0;
         r_halt <= 1'b0;
      end else if (!r_halt) begin
         r_step <= (r_step == T4) ? T0 : t_state_e'(r_step + 3'd1);
         if (r_step == T2 && w_is_hlt) r_halt <= 1'b1;
      end
   end

   always_comb begin
      hlt         = 1'b0;
      marIn       = 1'b0;
      ramIn       = 1'b0;
      ramOut      = 1'b0;
      irIn        = 1'b0;
      irOut       = 1'b0;
      aIn         = 1'b0;
      aOut        = 1'b0;
      bIn         = 1'b0;
      sumOut      = 1'b0;
      subtract    = 1'b0;
      outIn       = 1'b0;
      flagsIn     = 1'b0;
      pcOut       = 1'b0;
      countEnable = 1'b0;
      jump        = 1'b0;
      if (rst && r_halt) begin
         hlt = 1'b1;
      end else if (rst) begin
         case (r_step)
            T0: begin pcOut = 1'b1; marIn = 1'b1; end
            T1: begin ramOut = 1'b1; irIn = 1'b1; countEnable = 1'b1; end
            T2: begin
               hlt = w_is_hlt;
               case (w_op)
                  4'h1, 4'h2, 4'h3, 4'h4: begin irOut = 1'b1; marIn = 1'b1; end
                  4'h5: begin irOut = 1'b1; aIn = 1'b1; end
                  4'h6: begin irOut = 1'b1; jump = 1'b1; end
                  4'h7: begin irOut = 1'b1; jump = carryFlag; end
                  4'h8: begin irOut = 1'b1; jump = zeroFlag; end
                  4'hE: begin aOut = 1'b1; outIn = 1'b1; end
                  default: ;
               endcase
            end
            T3: begin
               case (w_op)
                  4'h1:       begin ramOut = 1'b1; aIn = 1'b1; end
                  4'h2, 4'h3: begin ramOut = 1'b1; bIn = 1'b1; end
                  4'h4:       begin aOut = 1'b1; ramIn = 1'b1; end
                  default: ;
               endcase
            end
            T4: begin
               if (w_op == 4'h2 || w_op == 4'h3) begin
                  sumOut   = 1'b1;
                  aIn      = 1'b1;
                  flagsIn  = 1'b1;
                  subtract = (w_op == 4'h3);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
